// File: rtl/data_mem_responder.sv
// Word-addressed load/store data memory behind a valid/ready request/response pair; optional DMEM_MISALIGN_ERR_EN faults addr[1:0]!=0.
// Latency: accept on edge N -> rsp_valid after edge N+LATENCY+1; one transaction outstanding.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_INIT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [3:0]      wait_cnt;
   logic            op_write;
   logic [31:2]     op_addr;
   logic [31:0]     op_wdata;
   logic [3:0]      op_wstrb;
   logic            op_misalign;
   logic            req_misalign;
   logic [31:0]     rdata_q;
   logic            err_q;
   logic [AW-1:0]   op_idx;
   logic            op_err;
   logic            accept;
   logic            access;
   logic            rsp_done;
   logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_MISALIGN_ERR_EN
   assign req_misalign = |req_addr[1:0];
`else
   // Sub-word address bits select nothing: the access always uses the aligned word.
   logic unused_addr_lo;
   assign unused_addr_lo = ^req_addr[1:0];
   assign req_misalign   = 1'b0;
`endif

   assign op_idx = op_addr[AW+1:2];
   assign op_err = (|op_addr[31:AW+2]) | op_misalign;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      access    = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               access    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt    <= 4'd0;
         op_write    <= 1'b0;
         op_addr     <= '0;
         op_wdata    <= 32'd0;
         op_wstrb    <= 4'd0;
         op_misalign <= 1'b0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            op_write    <= req_write;
            op_addr     <= req_addr[31:2];
            op_wdata    <= req_wdata;
            op_wstrb    <= req_wstrb;
            op_misalign <= req_misalign;
            wait_cnt    <= LAT_INIT;
         end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (access) begin
            err_q   <= op_err;
            rdata_q <= (!op_write && !op_err) ? mem[op_idx] : 32'd0;
         end else if (rsp_done) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
         end
      end
   end

   // Array is never reset; a reset racing the access edge must suppress the commit.
   always_ff @(posedge clk) begin
      if (!reset && access && op_write && !op_err) begin
         for (int b = 0; b < 4; b++) begin
            if (op_wstrb[b]) begin
               mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
            end
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed test-plan cases plus random traffic against a word-array model with a response scoreboard.
module tb_data_mem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;
   localparam int AW    = $clog2(DEPTH);

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [DEPTH];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          bp_rand   = 1'b0;
   bit          rsp_fixed = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rsp_ready = bp_rand ? ($urandom_range(0, 3) != 0) : rsp_fixed;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: memory is a plain word array; errors come from address range/alignment rules.
   function automatic void predict(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] ws, output logic [31:0] rd, output logic e);
      int idx;
      e = ((a >> (AW + 2)) != 0);
`ifdef DMEM_MISALIGN_ERR_EN
      e = e | (a % 4 != 0);
`endif
      idx = int'((a / 4) % DEPTH);
      rd  = 32'd0;
      if (w) begin
         if (!e) begin
            for (int b = 0; b < 4; b++) begin
               if (ws[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end else if (!e) begin
         rd = mdl[idx];
      end
   endfunction

   task automatic wait_ready(output bit ok);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
      if (!ok) fail_now("req_ready_timeout");
   endtask

   task automatic scramble();
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
   endtask

   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      bit   ok;
      exp_t e;
      wait_ready(ok);
      if (!ok) return;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = wd;
      req_wstrb = ws;
      predict(w, a, wd, ws, e.rdata, e.err);
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      scramble();
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         fail_now("drain_timeout");
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_rsp_valid();
      int n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) fail_now("rsp_valid_timeout");
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
      chk({tag, "_busy"},      32'(busy), 32'd0);
   endtask

   // Monitor: latency on first valid cycle, stability while held, data/err on handshake.
   logic        prev_hold = 1'b0;
   logic [31:0] hold_rd;
   logic        hold_err;
   always @(negedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else if (rsp_valid) begin
         chk("resp_req_ready_low", 32'(req_ready), 32'd0);
         if (!prev_hold) begin
            if (q.size() == 0) fail_now("unexpected_response");
            else chk("latency", 32'(cyc - q[0].acc), 32'(LAT + 1));
         end else begin
            chk("hold_rdata", rsp_rdata, hold_rd);
            chk("hold_err", 32'(rsp_err), 32'(hold_err));
         end
         if (rsp_ready) begin
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            prev_hold = 1'b0;
         end else begin
            prev_hold = 1'b1;
            hold_rd   = rsp_rdata;
            hold_err  = rsp_err;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      bit ok;
      reset = 1'b1;
      scramble();
      repeat (3) @(negedge clk);
      chk_reset_vals("por");
      reset = 1'b0;

      for (int i = 0; i < DEPTH; i++) send(1'b1, 32'(i * 4), $urandom, 4'hF);
      drain();

      // Full store then load, then byte-merge store
      send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      send(1'b0, 32'h10, 32'h0, 4'h0);
      send(1'b1, 32'h10, 32'h000000AA, 4'b0001);
      send(1'b0, 32'h10, 32'h0, 4'h0);
      drain();

      // Out-of-range and empty-strobe accesses
      send(1'b0, 32'h400, 32'h0, 4'h0);
      send(1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
      send(1'b0, 32'h0, 32'h0, 4'h0);
      send(1'b0, 32'h8000_0000, 32'h0, 4'h0);
      send(1'b1, 32'h30, 32'h55555555, 4'h0);
      send(1'b0, 32'h30, 32'h0, 4'h0);
      send(1'b0, 32'h3FC, 32'h0, 4'h0);
      drain();

      // Response backpressure
      rsp_fixed = 1'b0;
      @(posedge clk);
      send(1'b0, 32'h10, 32'h0, 4'h0);
      wait_rsp_valid();
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      rsp_fixed = 1'b1;
      drain();
      chk("bp_release_req_ready", 32'(req_ready), 32'd1);
      chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);

      // Reset while a store sits in WAIT: store must not commit
      wait_ready(ok);
      if (ok) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 32'h20;
         req_wdata = 32'h12345678;
         req_wstrb = 4'hF;
         @(posedge clk);
         #1;
         scramble();
         @(negedge clk);
         chk("wait_busy", 32'(busy), 32'd1);
         reset = 1'b1;
         @(negedge clk);
         chk_reset_vals("rst_wait");
         reset = 1'b0;
         q.delete();
      end
      send(1'b0, 32'h20, 32'h0, 4'h0);
      drain();

      // Reset while a response is pending
      rsp_fixed = 1'b0;
      @(posedge clk);
      send(1'b0, 32'h44, 32'h0, 4'h0);
      wait_rsp_valid();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst_resp");
      reset = 1'b0;
      q.delete();
      rsp_fixed = 1'b1;
      @(negedge clk);

      // Sub-word addresses
      send(1'b0, 32'h13, 32'h0, 4'h0);
      send(1'b1, 32'h15, 32'hA5A5_0F0F, 4'hF);
      send(1'b0, 32'h14, 32'h0, 4'h0);
      drain();

      // Random traffic with random response backpressure
      bp_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom;
            a[AW + 2 + $urandom_range(0, 31 - AW - 2)] = 1'b1;
         end else begin
            a = 32'($urandom_range(0, DEPTH * 4 - 1));
         end
         send(1'($urandom), a, $urandom, 4'($urandom));
      end
      drain();
      bp_rand = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
